// File: rtl/half_sched_pkg.sv
// Shared types for the half-precision accumulator scheduler.
// The result entry layout follows the package defaults for BITS and NUM_REQ.
package half_sched_pkg;

  localparam int unsigned BITS_DEF    = 16;
  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned LENGTH_DEF  = 10;

  localparam int unsigned ID_W  = $clog2(NUM_REQ_DEF);
  localparam int unsigned CNT_W = $clog2(LENGTH_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } sched_state_t;

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [BITS_DEF-1:0] sum;
  } res_entry_t;

endpackage

// File: rtl/sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above rr_ptr, wrapping.
module sched_rr_arbiter
  import half_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         gnt_oh,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [IdW-1:0] idx;
  logic           found;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = IdW'((32'(rr_ptr) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/half_accum_scheduler.sv
// Time-shares one half_stream_accumulate between NUM_REQ requesters, one vector per grant,
// and queues tagged results in a small fall-through FIFO.
module half_accum_scheduler
  import half_sched_pkg::*;
#(
  parameter int unsigned BITS      = BITS_DEF,
  parameter int unsigned LENGTH    = LENGTH_DEF,
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned RES_DEPTH = 2,
  parameter int unsigned DRAIN_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BITS-1:0]    req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       acc_in_valid,
  output logic [BITS-1:0]            acc_a,
  input  logic                       acc_out_valid,
  input  logic [BITS-1:0]            acc_c,
  output logic                       res_valid,
  output logic [BITS-1:0]            res_data,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  input  logic                       res_ready,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(LENGTH) + 1;
  localparam int unsigned TmrW = $clog2(DRAIN_MAX) + 1;
  localparam int unsigned PtrW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int unsigned FcW  = $clog2(RES_DEPTH + 1);

  sched_state_t       state_q, state_d;
  logic [IdW-1:0]     gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, arb_idx;
  logic [NUM_REQ-1:0] arb_oh;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [TmrW-1:0]    tmr_q, tmr_d;
  logic               err_q, err_d;

  res_entry_t         fifo_q [RES_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FcW-1:0]     fifo_cnt_q;
  logic               push, pop, fifo_full;

  logic [BITS-1:0]    req_beat [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_beat
    assign req_beat[i] = req_data[i*BITS +: BITS];
  end

  sched_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .gnt_oh (arb_oh),
    .gnt_idx(arb_idx)
  );

  assign fifo_full = (fifo_cnt_q == FcW'(RES_DEPTH));
  assign res_valid = (fifo_cnt_q != '0);
  assign pop       = res_valid & res_ready;
  assign res_data  = res_valid ? fifo_q[rd_ptr_q].sum : '0;
  assign res_id    = res_valid ? fifo_q[rd_ptr_q].id : '0;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    err_d        = err_q;
    push         = 1'b0;
    req_ready    = '0;
    acc_in_valid = 1'b0;
    acc_a        = '0;

    // A result from the accumulator is only expected while draining.
    if (acc_out_valid && state_q != DRAIN) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        // Grant only with a free result slot, so the eventual push can never overflow.
        if (|arb_oh && !fifo_full) begin
          gnt_d    = arb_idx;
          rr_ptr_d = (arb_idx == IdW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          cnt_d    = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        req_ready[gnt_q] = 1'b1;
        acc_in_valid     = req_valid[gnt_q];
        if (acc_in_valid) begin
          acc_a = req_beat[gnt_q];
          if (cnt_q == CntW'(LENGTH - 1)) begin
            cnt_d   = '0;
            tmr_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q != '0) begin
          // Mid-vector gap: the accumulator has already discarded its partial sum.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (acc_out_valid) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (tmr_q == TmrW'(DRAIN_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int unsigned i = 0; i < RES_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{id: gnt_q, sum: acc_c};
        wr_ptr_q         <= (wr_ptr_q == PtrW'(RES_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(RES_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + 1'b1;
      end else if (pop && !push) begin
        fifo_cnt_q <= fifo_cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_half_accum_scheduler.sv
// Bench for half_accum_scheduler: requester queues, an accumulator stand-in and a
// round-robin reference model predicting result order and sums.
module tb_half_accum_scheduler;

  localparam int unsigned BITS      = 16;
  localparam int unsigned LENGTH    = 4;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned RES_DEPTH = 2;
  localparam int unsigned DRAIN_MAX = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*BITS-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    acc_in_valid;
  logic [BITS-1:0]         acc_a;
  logic                    acc_out_valid;
  logic [BITS-1:0]         acc_c;
  logic                    res_valid;
  logic [BITS-1:0]         res_data;
  logic [1:0]              res_id;
  logic                    res_ready;
  logic                    busy;
  logic                    err;

  always #5 clk = ~clk;

  half_accum_scheduler #(
    .BITS     (BITS),
    .LENGTH   (LENGTH),
    .NUM_REQ  (NUM_REQ),
    .RES_DEPTH(RES_DEPTH),
    .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .acc_in_valid (acc_in_valid),
    .acc_a        (acc_a),
    .acc_out_valid(acc_out_valid),
    .acc_c        (acc_c),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_id       (res_id),
    .res_ready    (res_ready),
    .busy         (busy),
    .err          (err)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] vq [NUM_REQ][$];   // beats each requester still has to send
  logic [15:0] mq [NUM_REQ][$];   // model: expected sum per complete vector
  logic [17:0] exp_q [$];         // model: expected {id, sum} in pop order
  int          model_rr = 0;

  // Operand table; values are 0, 0.5, 1.0, 2.0 and in "halves" units 0, 1, 2, 4.
  logic [15:0] beat_tab   [4] = '{16'h0000, 16'h3800, 16'h3C00, 16'h4000};
  int          halves_tab [4] = '{0, 1, 2, 4};

  bit          suppress = 1'b0;
  int          acc_cnt  = 0;
  int          acc_sum  = 0;
  int          fire_dly = -1;
  logic [15:0] fire_val = '0;

  function automatic int half_to_halves(input logic [15:0] h);
    int e;
    if (h[14:0] == 15'd0) return 0;
    e = int'(h[14:10]);
    return ((1024 + int'(h[9:0])) << (e - 14)) >> 10;
  endfunction

  function automatic logic [15:0] halves_to_half(input int h);
    int k;
    int m;
    if (h == 0) return 16'h0000;
    k = 0;
    while ((2 << k) <= h) k++;
    m = ((h - (1 << k)) * 1024) >> k;
    return 16'(((k + 14) << 10) | m);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_vec(input int r, input int sel, input int nbeats);
    int sum;
    int s;
    sum = 0;
    for (int b = 0; b < nbeats; b++) begin
      s = (sel < 0) ? int'($urandom_range(0, 3)) : sel;
      vq[r].push_back(beat_tab[s]);
      sum += halves_tab[s];
    end
    if (nbeats == int'(LENGTH)) mq[r].push_back(halves_to_half(sum));
  endtask

  // Round robin from the spec: serve the first pending requester at or above the pointer.
  task automatic plan();
    bit any;
    int r;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        r = (model_rr + k) % NUM_REQ;
        if (!any && mq[r].size() > 0) begin
          exp_q.push_back({2'(r), mq[r].pop_front()});
          model_rr = (r + 1) % NUM_REQ;
          any = 1'b1;
        end
      end
    end
  endtask

  task automatic collect(input int budget);
    int cyc;
    logic [17:0] e;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      res_ready = ($urandom_range(0, 3) != 0);
      if (res_valid && res_ready) begin
        e = exp_q.pop_front();
        chk("res_id", 32'(res_id), 32'(e[17:16]));
        chk("res_data", 32'(res_data), 32'(e[15:0]));
      end
      cyc++;
    end
    chk("collect_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      vq[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_req_ready"}, 32'(req_ready), 0);
    chk({pfx, "_acc_in_valid"}, 32'(acc_in_valid), 0);
    chk({pfx, "_acc_a"}, 32'(acc_a), 0);
    chk({pfx, "_res_valid"}, 32'(res_valid), 0);
    chk({pfx, "_res_data"}, 32'(res_data), 0);
    chk({pfx, "_res_id"}, 32'(res_id), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_err"}, 32'(err), 0);
  endtask

  // Requester drivers: present the queue head, drop it once accepted.
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (vq[i].size() > 0) begin
          req_valid[i]               = 1'b1;
          req_data[i*BITS +: BITS]   = vq[i][0];
        end else begin
          req_valid[i]               = 1'b0;
          req_data[i*BITS +: BITS]   = '0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!rst && req_valid[i] && req_ready[i] && vq[i].size() > 0) void'(vq[i].pop_front());
      end
    end
  end

  // Accumulator stand-in: sums LENGTH beats, answers 0..2 cycles later, clears on a gap.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        acc_cnt  = 0;
        acc_sum  = 0;
        fire_dly = -1;
      end else if (acc_in_valid) begin
        acc_sum += half_to_halves(acc_a);
        acc_cnt++;
        if (acc_cnt == int'(LENGTH)) begin
          if (!suppress) begin
            fire_val = halves_to_half(acc_sum);
            fire_dly = int'($urandom_range(0, 2));
          end
          acc_cnt = 0;
          acc_sum = 0;
        end
      end else begin
        acc_cnt = 0;
        acc_sum = 0;
      end
    end
  end

  initial begin
    acc_out_valid = 1'b0;
    acc_c         = '0;
    forever begin
      @(negedge clk);
      acc_out_valid = 1'b0;
      acc_c         = '0;
      if (fire_dly == 0) begin
        acc_out_valid = 1'b1;
        acc_c         = fire_val;
        fire_dly      = -1;
      end else if (fire_dly > 0) begin
        fire_dly--;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int mask;
    rst       = 1'b1;
    res_ready = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single requester, 4 x 1.0 -> 4.0 tagged with id 1.
    add_vec(1, 2, LENGTH);
    plan();
    chk("p1_plan_sum", 32'(exp_q[0][15:0]), 32'h4400);
    collect(200);
    chk("p1_err", 32'(err), 0);

    // Two contending requesters, two vectors of 4 x 0.5 each.
    add_vec(0, 1, LENGTH);
    add_vec(0, 1, LENGTH);
    add_vec(2, 1, LENGTH);
    add_vec(2, 1, LENGTH);
    plan();
    collect(300);

    // Result FIFO full: the third pending requester must wait for a pop.
    add_vec(0, -1, LENGTH);
    add_vec(1, -1, LENGTH);
    add_vec(3, -1, LENGTH);
    plan();
    repeat (60) @(negedge clk);
    chk("full_res_valid", 32'(res_valid), 1);
    chk("full_busy", 32'(busy), 0);
    chk("full_req_ready", 32'(req_ready), 0);
    collect(300);

    // Random contention rounds with random consumer back-pressure.
    for (int rnd = 0; rnd < 8; rnd++) begin
      mask = int'($urandom_range(1, 15));
      for (int r = 0; r < int'(NUM_REQ); r++) begin
        if (mask[r]) begin
          for (int v = 0; v < int'($urandom_range(1, 2)); v++) add_vec(r, -1, LENGTH);
        end
      end
      plan();
      collect(600);
    end
    chk("rand_err", 32'(err), 0);
    chk("rand_busy", 32'(busy), 0);

    // Requester 3 stops after two beats: error, nothing queued.
    add_vec(3, 2, 2);
    model_rr = 0;
    c = 0;
    while (!err && c < 50) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    chk("abort_err", 32'(err), 1);
    chk("abort_res_valid", 32'(res_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    add_vec(0, 2, LENGTH);
    plan();
    collect(200);

    // Accumulator never answers: DRAIN gives up after DRAIN_MAX cycles.
    do_reset();
    suppress = 1'b1;
    add_vec(2, 1, LENGTH);
    mq[2].delete();
    c = 0;
    while (vq[2].size() > 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("to_beats_sent", vq[2].size(), 0);
    repeat (DRAIN_MAX - 1) @(negedge clk);
    chk("to_busy_before", 32'(busy), 1);
    chk("to_err_before", 32'(err), 0);
    @(negedge clk);
    chk("to_busy_after", 32'(busy), 0);
    chk("to_err_after", 32'(err), 1);
    suppress = 1'b0;

    // Reset in the middle of a stream with one result held in the FIFO.
    add_vec(0, 1, LENGTH);
    mq[0].delete();
    repeat (25) @(negedge clk);
    chk("mid_fifo_loaded", 32'(res_valid), 1);
    add_vec(1, 2, LENGTH);
    mq[1].delete();
    c = 0;
    while (vq[1].size() > 2 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("mid_streaming", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    for (int i = 0; i < int'(NUM_REQ); i++) vq[i].delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
    // A pointer left at 2 would serve requester 3 first.
    add_vec(1, -1, LENGTH);
    add_vec(3, -1, LENGTH);
    plan();
    collect(300);
    chk("final_err", 32'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/half_accum_scheduler.md
Name: half_accum_scheduler

Overview:
Shares one half_stream_accumulate instance (half-precision dot-product reduction) between NUM_REQ streaming requesters in the neural-network datapath. It grants one requester per vector in round-robin order and forwards that requester's LENGTH contiguous beats to the accumulator. Each accumulated result is tagged with the requester index and queued in a small result FIFO with valid/ready output. Ungranted requesters and the result consumer are flow-controlled.

Parameters:
BITS, 16, operand/result width (IEEE half).
LENGTH, 10, beats per vector; must equal the accumulator's LENGTH.
NUM_REQ, 4, number of requesters (>=2).
RES_DEPTH, 2, result FIFO entries (>=1).
DRAIN_MAX, 8, cycles allowed between the last beat and acc_out_valid before timeout.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester beat valid.
req_data  in  NUM_REQ*BITS  per-requester beat; requester i occupies [i*BITS +: BITS].
req_ready  out  NUM_REQ  one-hot; beat accepted when req_valid[i] & req_ready[i].
acc_in_valid  out  1  to accumulator in_valid.
acc_a  out  BITS  to accumulator a.
acc_out_valid  in  1  from accumulator out_valid.
acc_c  in  BITS  from accumulator c.
res_valid  out  1  result FIFO not empty.
res_data  out  BITS  head result sum.
res_id  out  $clog2(NUM_REQ)  head result requester index.
res_ready  in  1  consumer pops head when res_valid & res_ready.
busy  out  1  state != IDLE.
err  out  1  sticky protocol/timeout error; cleared only by rst.

Behaviour:
- Reset, async on rst high: state=IDLE; req_ready=0, acc_in_valid=0, acc_a=0, res_valid=0, res_data=0, res_id=0, busy=0, err=0; FIFO empty; rr_ptr=0; beat count=0.
- States: IDLE, STREAM, DRAIN.
- IDLE: if any req_valid and fifo_count<RES_DEPTH, grant the first requesting index searching from rr_ptr upward modulo NUM_REQ. Register gnt, set rr_ptr=gnt+1 mod NUM_REQ, go to STREAM. No beat is accepted in the grant cycle. If the FIFO is full, no grant is made and the state stays IDLE.
- STREAM: req_ready[gnt]=1, all other req_ready bits 0. acc_in_valid=req_valid[gnt] and acc_a=req_data[gnt], combinational pass-through with zero added latency. acc_a=0 whenever acc_in_valid=0.
  - Each accepted beat increments the beat count. On the accepted beat where count==LENGTH-1: count<=0, go to DRAIN.
  - If req_valid[gnt] is 0 while count>0: abort. Set err=1, count<=0, go to IDLE. The accumulator self-clears when in_valid drops, and no result is pushed.
  - If req_valid[gnt] is 0 while count==0: wait in STREAM, no error.
- DRAIN: req_ready=0, acc_in_valid=0, timer counts cycles.
  - On acc_out_valid: push {gnt, acc_c} into the FIFO and go to IDLE. A FIFO slot is guaranteed because it was reserved at grant time.
  - If the timer reaches DRAIN_MAX without acc_out_valid: set err=1, go to IDLE, push nothing.
- acc_out_valid outside DRAIN is ignored and sets err=1.
- Result FIFO: first-word fall-through. Simultaneous push and pop on a full FIFO is legal, and the count is unchanged. Pop on empty is ignored.
- Throughput: LENGTH+1+drain-latency cycles per vector. No overlap of vectors.
- Fairness: a requester holding req_valid high is granted within NUM_REQ-1 other vectors.
- Width rules: beat count is $clog2(LENGTH)+1 bits; DRAIN timer is $clog2(DRAIN_MAX)+1 bits; the scheduler performs no arithmetic on data.

Decomposition:
- Package half_sched_pkg holds:
  - state enum sched_state_t {IDLE, STREAM, DRAIN};
  - struct res_entry_t {id, sum};
  - localparams ID_W=$clog2(NUM_REQ) and CNT_W.
- One sub-module: sched_rr_arbiter, parameterised by NUM_REQ. Inputs req vector and rr_ptr; outputs a one-hot grant and an index, combinational only.
- The FIFO is inline.

Test Plan:
LENGTH=4, requester 1 streams 4×0x3C00 (1.0) -> req_ready[1] high for 4 beats; res_valid with res_data=0x4400 (4.0), res_id=1; err=0.
Requesters 0 and 2 both assert continuously with 4×0x3800 (0.5) -> grant order 0, 2, 0, 2; each result is 0x4000 (2.0) with the matching res_id.
res_ready=0, RES_DEPTH=2, three requesters pending -> two results queued; third not granted (req_ready=0, busy=0) until one pop, then granted.
Requester 3 drops req_valid after 2 beats -> err=1, no result pushed; the next vector from requester 0 (4×0x3C00) still yields 0x4400.
acc_out_valid forced low in DRAIN -> after DRAIN_MAX cycles, err=1 and state returns to IDLE; assert rst mid-STREAM -> all outputs 0 immediately, FIFO empty, rr_ptr=0.
